// File: rtl/pe_ld_st_server.sv
// pe_ld_st_server
//
// Memory-side responder for the PE functional unit's load and store
// interfaces, built around a local 1R1W data memory.
//
// Loads: a stream length arrives on ld_stream_len/ld_stream_len_vld. That
// many descriptors are then accepted on ld_desc_*. Each accepted descriptor
// reads memory, and the word appears one cycle later on load port 0 or 1
// together with its destination register address. The word is held until
// the port's rdy.
//
// Stores: words arrive on st_req/st_ack. Each word goes through a one-entry
// stage to sequential addresses taken from the store pointer. st_base_ld
// reloads the pointer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ld_stream_len[_vld] stream length and its one-cycle strobe
//   ld_desc_*           load descriptor (mem addr, reg addr, port) + vld/rdy
//   ld_{0,1}_*          load result ports: data, reg addr, vld/rdy
//   st_data/st_req/st_ack    store word handshake
//   st_base/st_base_ld       store pointer reload
//   all_stored          no store pending in the stage or on st_req
//   ld_busy             stream active or load data still undelivered
//   ld_len_err          stream length seen while busy (one-cycle pulse)
//
// Build option:
//   PE_LD_ST_SERVER_ST_FWD_EN  forward store-stage data to a colliding load
//                              instead of stalling that load for one cycle.

module pe_ld_st_server #(
   parameter int unsigned DATA_L          = 32,
   parameter int unsigned REG_ADDR_L      = 5,
   parameter int unsigned LD_STREAM_CNT_L = 8,
   parameter int unsigned MEM_DEPTH       = 512,
   parameter int unsigned MEM_ADDR_L      = $clog2(MEM_DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [LD_STREAM_CNT_L-1:0] ld_stream_len,
   input  logic                       ld_stream_len_vld,
   input  logic [MEM_ADDR_L-1:0]      ld_desc_mem_addr,
   input  logic [REG_ADDR_L-1:0]      ld_desc_reg_addr,
   input  logic                       ld_desc_port,
   input  logic                       ld_desc_vld,
   output logic                       ld_desc_rdy,
   output logic [DATA_L-1:0]          ld_0_data,
   output logic [REG_ADDR_L-1:0]      ld_0_addr,
   output logic                       ld_0_vld,
   input  logic                       ld_0_rdy,
   output logic [DATA_L-1:0]          ld_1_data,
   output logic [REG_ADDR_L-1:0]      ld_1_addr,
   output logic                       ld_1_vld,
   input  logic                       ld_1_rdy,
   input  logic [DATA_L-1:0]          st_data,
   input  logic                       st_req,
   output logic                       st_ack,
   input  logic [MEM_ADDR_L-1:0]      st_base,
   input  logic                       st_base_ld,
   output logic                       all_stored,
   output logic                       ld_busy,
   output logic                       ld_len_err
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

   state_e                     state_q, state_d;
   logic [LD_STREAM_CNT_L-1:0] rem_q, rem_d;
   logic                       len_err_q, len_err_d;

   logic                       ld0_vld_q, ld0_vld_d;
   logic [DATA_L-1:0]          ld0_data_q, ld0_data_d;
   logic [REG_ADDR_L-1:0]      ld0_addr_q, ld0_addr_d;
   logic                       ld1_vld_q, ld1_vld_d;
   logic [DATA_L-1:0]          ld1_data_q, ld1_data_d;
   logic [REG_ADDR_L-1:0]      ld1_addr_q, ld1_addr_d;

   logic [MEM_ADDR_L-1:0]      st_ptr_q, st_ptr_d;
   logic                       stg_vld_q, stg_vld_d;
   logic [MEM_ADDR_L-1:0]      stg_addr_q, stg_addr_d;
   logic [DATA_L-1:0]          stg_data_q, stg_data_d;

   logic [DATA_L-1:0]          mem_q [MEM_DEPTH];

   logic                       tgt_vld, tgt_rdy, slot_ok;
   logic                       hazard, hazard_stall;
   logic                       ld_acc;
   logic                       stg_wr;
   logic [DATA_L-1:0]          ld_word;

   // Target output slot can take a new word if empty or handing off now.
   assign tgt_vld = ld_desc_port ? ld1_vld_q : ld0_vld_q;
   assign tgt_rdy = ld_desc_port ? ld_1_rdy  : ld_0_rdy;
   assign slot_ok = !tgt_vld || tgt_rdy;

   // A load that collides with the pending store-stage entry would read
   // stale memory, because the stage writes at the end of this cycle.
   assign hazard = stg_vld_q && (ld_desc_mem_addr == stg_addr_q);

`ifdef PE_LD_ST_SERVER_ST_FWD_EN
   assign hazard_stall = 1'b0;
   assign ld_word      = hazard ? stg_data_q : mem_q[ld_desc_mem_addr];
`else
   assign hazard_stall = hazard;
   assign ld_word      = mem_q[ld_desc_mem_addr];
`endif

   assign ld_acc = ld_desc_vld && ld_desc_rdy;

   // ---------------- load FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         len_err_q <= len_err_d;
      end
   end

   // ---------------- load FSM: next state ----------------
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      len_err_d = ld_stream_len_vld && (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (ld_stream_len_vld && (ld_stream_len != '0)) begin
               rem_d   = ld_stream_len;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (ld_acc) begin
               rem_d = rem_q - LD_STREAM_CNT_L'(1);
               if (rem_q == LD_STREAM_CNT_L'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!ld0_vld_q && !ld1_vld_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- load FSM: outputs ----------------
   always_comb begin
      ld_desc_rdy = (state_q == STREAM) && (rem_q != '0) && slot_ok && !hazard_stall;
      ld_busy     = (state_q != IDLE);
   end

   assign ld_len_err = len_err_q;

   // ---------------- load output slots and store stage ----------------
   // The stage empties every cycle it is valid, so an ack never waits.
   assign stg_wr     = stg_vld_q;
   assign st_ack     = st_req && (!stg_vld_q || stg_wr);
   assign all_stored = !stg_vld_q && !st_req;

   always_comb begin
      ld0_vld_d  = ld0_vld_q;
      ld0_data_d = ld0_data_q;
      ld0_addr_d = ld0_addr_q;
      ld1_vld_d  = ld1_vld_q;
      ld1_data_d = ld1_data_q;
      ld1_addr_d = ld1_addr_q;

      if (ld0_vld_q && ld_0_rdy) ld0_vld_d = 1'b0;
      if (ld1_vld_q && ld_1_rdy) ld1_vld_d = 1'b0;

      if (ld_acc && !ld_desc_port) begin
         ld0_vld_d  = 1'b1;
         ld0_data_d = ld_word;
         ld0_addr_d = ld_desc_reg_addr;
      end
      if (ld_acc && ld_desc_port) begin
         ld1_vld_d  = 1'b1;
         ld1_data_d = ld_word;
         ld1_addr_d = ld_desc_reg_addr;
      end

      stg_vld_d  = st_ack;
      stg_data_d = stg_data_q;
      stg_addr_d = stg_addr_q;
      if (st_ack) begin
         stg_data_d = st_data;
         stg_addr_d = st_ptr_q;
      end

      // A reload wins over the increment; the acked word keeps the old pointer.
      st_ptr_d = st_ptr_q;
      if (st_base_ld) begin
         st_ptr_d = st_base;
      end else if (st_ack) begin
         st_ptr_d = st_ptr_q + MEM_ADDR_L'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ld0_vld_q  <= 1'b0;
         ld0_data_q <= '0;
         ld0_addr_q <= '0;
         ld1_vld_q  <= 1'b0;
         ld1_data_q <= '0;
         ld1_addr_q <= '0;
         st_ptr_q   <= '0;
         stg_vld_q  <= 1'b0;
         stg_addr_q <= '0;
         stg_data_q <= '0;
      end else begin
         ld0_vld_q  <= ld0_vld_d;
         ld0_data_q <= ld0_data_d;
         ld0_addr_q <= ld0_addr_d;
         ld1_vld_q  <= ld1_vld_d;
         ld1_data_q <= ld1_data_d;
         ld1_addr_q <= ld1_addr_d;
         st_ptr_q   <= st_ptr_d;
         stg_vld_q  <= stg_vld_d;
         stg_addr_q <= stg_addr_d;
         stg_data_q <= stg_data_d;
      end
   end

   // Memory is not reset; a reset discards a pending stage write.
   always_ff @(posedge clk) begin
      if (stg_wr && !rst) begin
         mem_q[stg_addr_q] <= stg_data_q;
      end
   end

   assign ld_0_vld  = ld0_vld_q;
   assign ld_0_data = ld0_data_q;
   assign ld_0_addr = ld0_addr_q;
   assign ld_1_vld  = ld1_vld_q;
   assign ld_1_data = ld1_data_q;
   assign ld_1_addr = ld1_addr_q;

endmodule

// File: tb/tb_pe_ld_st_server.sv
// Scoreboard bench for pe_ld_st_server. The reference is a plain array
// memory with a store pointer. Each load returns the array contents as they
// were before any store acked in that same cycle.
module tb_pe_ld_st_server;

   localparam int unsigned DATA_L = 32;
   localparam int unsigned RA_L   = 5;
   localparam int unsigned CNT_L  = 8;
   localparam int unsigned DEPTH  = 512;
   localparam int unsigned AW     = 9;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [CNT_L-1:0]  ld_stream_len = '0;
   logic              ld_stream_len_vld = 1'b0;
   logic [AW-1:0]     ld_desc_mem_addr = '0;
   logic [RA_L-1:0]   ld_desc_reg_addr = '0;
   logic              ld_desc_port = 1'b0;
   logic              ld_desc_vld = 1'b0;
   logic              ld_desc_rdy;
   logic [DATA_L-1:0] ld_0_data, ld_1_data;
   logic [RA_L-1:0]   ld_0_addr, ld_1_addr;
   logic              ld_0_vld, ld_1_vld;
   logic              ld_0_rdy = 1'b1;
   logic              ld_1_rdy = 1'b1;
   logic [DATA_L-1:0] st_data = '0;
   logic              st_req = 1'b0;
   logic              st_ack;
   logic [AW-1:0]     st_base = '0;
   logic              st_base_ld = 1'b0;
   logic              all_stored, ld_busy, ld_len_err;

   always #5 clk = ~clk;

   pe_ld_st_server #(
      .DATA_L(DATA_L), .REG_ADDR_L(RA_L), .LD_STREAM_CNT_L(CNT_L),
      .MEM_DEPTH(DEPTH), .MEM_ADDR_L(AW)
   ) dut (
      .clk(clk), .rst(rst),
      .ld_stream_len(ld_stream_len), .ld_stream_len_vld(ld_stream_len_vld),
      .ld_desc_mem_addr(ld_desc_mem_addr), .ld_desc_reg_addr(ld_desc_reg_addr),
      .ld_desc_port(ld_desc_port), .ld_desc_vld(ld_desc_vld), .ld_desc_rdy(ld_desc_rdy),
      .ld_0_data(ld_0_data), .ld_0_addr(ld_0_addr), .ld_0_vld(ld_0_vld), .ld_0_rdy(ld_0_rdy),
      .ld_1_data(ld_1_data), .ld_1_addr(ld_1_addr), .ld_1_vld(ld_1_vld), .ld_1_rdy(ld_1_rdy),
      .st_data(st_data), .st_req(st_req), .st_ack(st_ack),
      .st_base(st_base), .st_base_ld(st_base_ld),
      .all_stored(all_stored), .ld_busy(ld_busy), .ld_len_err(ld_len_err)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [DATA_L+RA_L-1:0] exp_q0[$];
   logic [DATA_L+RA_L-1:0] exp_q1[$];
   logic [DATA_L-1:0]      ref_mem [DEPTH];
   int unsigned            ref_ptr = 0;

   logic                   p0v = 1'b0, p1v = 1'b0;
   logic [DATA_L+RA_L-1:0] p0w, p1w;
   logic                   done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor and reference model, sampled on the falling edge.
   always @(negedge clk) begin
      logic [DATA_L+RA_L-1:0] e;
      if (rst) begin
         exp_q0.delete();
         exp_q1.delete();
         p0v = 1'b0;
         p1v = 1'b0;
         ref_ptr = 0;
      end else begin
         if (p0v) begin
            chk("ld0_hold_vld", 64'(ld_0_vld), 64'd1);
            chk("ld0_hold_word", 64'({ld_0_data, ld_0_addr}), 64'(p0w));
         end
         if (p1v) begin
            chk("ld1_hold_vld", 64'(ld_1_vld), 64'd1);
            chk("ld1_hold_word", 64'({ld_1_data, ld_1_addr}), 64'(p1w));
         end
         if (ld_0_vld && ld_0_rdy) begin
            if (exp_q0.size() == 0) chk("ld0_unexpected", 64'd1, 64'd0);
            else begin
               e = exp_q0.pop_front();
               chk("ld0_word", 64'({ld_0_data, ld_0_addr}), 64'(e));
            end
         end
         if (ld_1_vld && ld_1_rdy) begin
            if (exp_q1.size() == 0) chk("ld1_unexpected", 64'd1, 64'd0);
            else begin
               e = exp_q1.pop_front();
               chk("ld1_word", 64'({ld_1_data, ld_1_addr}), 64'(e));
            end
         end
         p0v = ld_0_vld && !ld_0_rdy;
         p0w = {ld_0_data, ld_0_addr};
         p1v = ld_1_vld && !ld_1_rdy;
         p1w = {ld_1_data, ld_1_addr};

         // A load sees memory as it was before stores acked this cycle.
         if (ld_desc_vld && ld_desc_rdy) begin
            if (ld_desc_port) exp_q1.push_back({ref_mem[ld_desc_mem_addr], ld_desc_reg_addr});
            else              exp_q0.push_back({ref_mem[ld_desc_mem_addr], ld_desc_reg_addr});
         end
         if (st_req) chk("st_ack", 64'(st_ack), 64'd1);
         if (st_req && st_ack) ref_mem[ref_ptr] = st_data;
         if (st_base_ld) ref_ptr = int'(st_base);
         else if (st_req && st_ack) ref_ptr = (ref_ptr + 1) % DEPTH;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_stream(input int unsigned len);
      ld_stream_len = CNT_L'(len);
      ld_stream_len_vld = 1'b1;
      cyc();
      ld_stream_len_vld = 1'b0;
   endtask

   task automatic send_desc(input logic [AW-1:0] a, input logic [RA_L-1:0] r, input logic p);
      logic acc;
      int n;
      ld_desc_mem_addr = a;
      ld_desc_reg_addr = r;
      ld_desc_port = p;
      ld_desc_vld = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = ld_desc_rdy;
         cyc();
         n++;
      end
      ld_desc_vld = 1'b0;
      if (!acc) chk("desc_timeout", 64'd1, 64'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (ld_busy && n < 200) begin
         cyc();
         n++;
      end
      chk("busy_clear", 64'(ld_busy), 64'd0);
   endtask

   task automatic store_at(input logic [AW-1:0] base, input logic [DATA_L-1:0] d0,
                           input logic [DATA_L-1:0] d1);
      st_base = base;
      st_base_ld = 1'b1;
      cyc();
      st_base_ld = 1'b0;
      st_req = 1'b1;
      st_data = d0;
      #1 chk("st_ack_first", 64'(st_ack), 64'd1);
      cyc();
      st_data = d1;
      #1 chk("st_ack_second", 64'(st_ack), 64'd1);
      cyc();
      st_req = 1'b0;
   endtask

   initial begin
      logic exp_hz_rdy;

      repeat (3) cyc();
      rst = 1'b0;
      chk("rst_ld0_vld", 64'(ld_0_vld), 64'd0);
      chk("rst_ld1_vld", 64'(ld_1_vld), 64'd0);
      chk("rst_desc_rdy", 64'(ld_desc_rdy), 64'd0);
      chk("rst_st_ack", 64'(st_ack), 64'd0);
      chk("rst_busy", 64'(ld_busy), 64'd0);
      chk("rst_len_err", 64'(ld_len_err), 64'd0);
      chk("rst_all_stored", 64'(all_stored), 64'd1);
      chk("rst_ld0_out", 64'({ld_0_data, ld_0_addr}), 64'd0);
      chk("rst_ld1_out", 64'({ld_1_data, ld_1_addr}), 64'd0);

      // Fill every word so later loads never see uninitialised memory.
      st_base_ld = 1'b1;
      st_base = '0;
      cyc();
      st_base_ld = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         st_req = 1'b1;
         st_data = $urandom;
         cyc();
      end
      st_req = 1'b0;
      cyc();

      // Basic store and all_stored timing.
      store_at(AW'(10), 32'hA, 32'hB);
      #1 chk("all_stored_pending", 64'(all_stored), 64'd0);
      cyc();
      chk("all_stored_done", 64'(all_stored), 64'd1);

      // Basic stream with latency-1 outputs.
      start_stream(2);
      chk("stream_busy", 64'(ld_busy), 64'd1);
      send_desc(AW'(10), RA_L'(3), 1'b0);
      chk("basic_ld0", 64'({ld_0_vld, ld_0_data, ld_0_addr}), {27'd0, 1'b1, 32'hA, 5'd3});
      send_desc(AW'(11), RA_L'(4), 1'b1);
      chk("basic_ld1", 64'({ld_1_vld, ld_1_data, ld_1_addr}), {27'd0, 1'b1, 32'hB, 5'd4});
      wait_idle();

      // Zero length is a no-op.
      start_stream(0);
      chk("len0_busy", 64'(ld_busy), 64'd0);
      chk("len0_rdy", 64'(ld_desc_rdy), 64'd0);

      // Length while streaming: one error pulse, remaining untouched.
      start_stream(3);
      send_desc(AW'(12), RA_L'(1), 1'b1);
      start_stream(7);
      chk("len_err_pulse", 64'(ld_len_err), 64'd1);
      cyc();
      chk("len_err_clear", 64'(ld_len_err), 64'd0);
      send_desc(AW'(13), RA_L'(2), 1'b0);
      chk("len_err_still_busy", 64'(ld_busy), 64'd1);
      send_desc(AW'(14), RA_L'(3), 1'b1);
      wait_idle();

      // Backpressure on port 0.
      start_stream(2);
      ld_0_rdy = 1'b0;
      send_desc(AW'(13), RA_L'(5), 1'b0);
      ld_desc_mem_addr = AW'(14);
      ld_desc_reg_addr = RA_L'(6);
      ld_desc_port = 1'b0;
      ld_desc_vld = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 chk("bp_desc_blocked", 64'(ld_desc_rdy), 64'd0);
         chk("bp_ld0_vld", 64'(ld_0_vld), 64'd1);
         cyc();
      end
      ld_0_rdy = 1'b1;
      #1 chk("bp_desc_drain", 64'(ld_desc_rdy), 64'd1);
      cyc();
      ld_desc_vld = 1'b0;
      wait_idle();

      // Store pointer wraps from the last word to address 0.
      store_at(AW'(DEPTH - 1), 32'h1234_5678, 32'hCAFE_0001);
      cyc();
      start_stream(2);
      send_desc(AW'(DEPTH - 1), RA_L'(8), 1'b1);
      chk("wrap_last", 64'(ld_1_data), 64'h1234_5678);
      send_desc(AW'(0), RA_L'(9), 1'b0);
      chk("wrap_zero", 64'(ld_0_data), 64'hCAFE_0001);
      wait_idle();

      // Load right behind a store to the same address.
      start_stream(1);
      st_base = AW'(20);
      st_base_ld = 1'b1;
      cyc();
      st_base_ld = 1'b0;
      st_req = 1'b1;
      st_data = 32'h55;
      cyc();
      st_req = 1'b0;
      ld_desc_mem_addr = AW'(20);
      ld_desc_reg_addr = RA_L'(7);
      ld_desc_port = 1'b0;
      ld_desc_vld = 1'b1;
`ifdef PE_LD_ST_SERVER_ST_FWD_EN
      exp_hz_rdy = 1'b1;
`else
      exp_hz_rdy = 1'b0;
`endif
      #1 chk("hazard_rdy", 64'(ld_desc_rdy), 64'(exp_hz_rdy));
      send_desc(AW'(20), RA_L'(7), 1'b0);
      chk("hazard_data", 64'(ld_0_data), 64'h55);
      wait_idle();

      // Reset in the middle of a stream.
      start_stream(4);
      ld_0_rdy = 1'b0;
      send_desc(AW'(21), RA_L'(10), 1'b0);
      chk("pre_rst_vld", 64'(ld_0_vld), 64'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst_vld", 64'({ld_0_vld, ld_1_vld}), 64'd0);
      chk("mid_rst_busy", 64'(ld_busy), 64'd0);
      chk("mid_rst_all_stored", 64'(all_stored), 64'd1);
      ld_0_rdy = 1'b1;
      start_stream(1);
      send_desc(AW'(10), RA_L'(2), 1'b0);
      chk("post_rst_ld0", 64'(ld_0_data), 64'hA);
      wait_idle();

      // Randomised traffic with concurrent stores on a small address window.
      fork
         begin
            for (int s = 0; s < 40; s++) begin
               start_stream($urandom_range(1, 6));
               for (int i = 0; i < int'(ld_stream_len); i++)
                  send_desc(AW'($urandom_range(0, 31)), RA_L'($urandom), 1'($urandom_range(0, 1)));
               wait_idle();
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               ld_0_rdy = ($urandom_range(0, 3) != 0);
               ld_1_rdy = ($urandom_range(0, 3) != 0);
               cyc();
            end
            ld_0_rdy = 1'b1;
            ld_1_rdy = 1'b1;
         end
         begin
            while (!done) begin
               st_req = 1'($urandom_range(0, 1));
               st_data = $urandom;
               st_base_ld = ($urandom_range(0, 7) == 0);
               st_base = AW'($urandom_range(0, 31));
               cyc();
            end
            st_req = 1'b0;
            st_base_ld = 1'b0;
         end
      join

      repeat (5) cyc();
      chk("q0_drained", 64'(exp_q0.size()), 64'd0);
      chk("q1_drained", 64'(exp_q1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pe_ld_st_server.md
Name: pe_ld_st_server

Overview:
- Memory-side responder for the PE functional unit's load and store interfaces.
- Receives a load stream length from the functional unit, then accepts that many load descriptors.
- For each descriptor: reads the local data memory, drives data plus destination register address on load port 0 or 1 with a vld/rdy handshake.
- Accepts stores on the st_req/st_ack handshake into sequential memory addresses; reports all_stored for local barriers.

Parameters:
- DATA_L, 32, data word width.
- REG_ADDR_L, 5, PE register address width.
- LD_STREAM_CNT_L, 8, load stream length width.
- MEM_DEPTH, 512, words in local data memory (power of 2).
- MEM_ADDR_L, $clog2(MEM_DEPTH), memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ld_stream_len  in  LD_STREAM_CNT_L  number of loads in next stream
- ld_stream_len_vld  in  1  stream length valid (one-cycle pulse)
- ld_desc_mem_addr  in  MEM_ADDR_L  load source address
- ld_desc_reg_addr  in  REG_ADDR_L  destination register
- ld_desc_port  in  1  0 = ld_0, 1 = ld_1
- ld_desc_vld  in  1  descriptor valid
- ld_desc_rdy  out  1  descriptor accepted
- ld_0_data  out  DATA_L  load port 0 data
- ld_0_addr  out  REG_ADDR_L  load port 0 register address
- ld_0_vld  out  1  port 0 valid
- ld_0_rdy  in  1  port 0 ready
- ld_1_data, ld_1_addr, ld_1_vld, ld_1_rdy: same as port 0, for port 1
- st_data  in  DATA_L  store data
- st_req  in  1  store request
- st_ack  out  1  store accepted
- st_base  in  MEM_ADDR_L  store pointer load value
- st_base_ld  in  1  load st_base into store pointer
- all_stored  out  1  no store pending
- ld_busy  out  1  stream active or load data undelivered
- ld_len_err  out  1  length received while busy (one-cycle pulse)

Behaviour:
- Reset and clocking:
  - Single clock clk. Reset rst is synchronous, active-high.
  - Reset values: all vld outputs 0, ld_desc_rdy 0, st_ack 0, ld_busy 0, ld_len_err 0, all_stored 1.
  - Reset values: remaining count 0, store pointer 0, state IDLE, data/addr outputs 0.
  - Memory contents are not reset.
  - Reset mid-stream discards all pending load and store state.
- Load FSM states:
  - IDLE: on ld_stream_len_vld with len != 0, load remaining = len and go to STREAM. len == 0 stays in IDLE with no effect.
  - STREAM: ld_desc_rdy = (remaining != 0) & target output slot free-or-draining & no hazard. Accept = ld_desc_vld & ld_desc_rdy, which decrements remaining. When remaining reaches 0, go to DRAIN.
  - DRAIN: return to IDLE when ld_0_vld == 0 and ld_1_vld == 0.
  - ld_stream_len_vld outside IDLE is ignored, and ld_len_err pulses 1 cycle later.
- Load output slots:
  - The target slot is the output register selected by ld_desc_port. It is "free" if its vld = 0 and "draining" if vld & rdy this cycle.
  - Latency is 1: the synchronous memory read on accept writes the output register; data, addr and vld appear the next cycle.
  - vld is held with stable data and addr until rdy. Ports 0 and 1 are independent, so both may hand off in the same cycle.
  - Back-to-back accepts to the same port at full throughput require rdy = 1 every cycle.
- ld_busy = (state != IDLE).
- Store path:
  - One-entry store stage.
  - st_ack = st_req & (stage empty | stage writing this cycle); combinational, with a 1-cycle pulse per word.
  - On ack, latch st_data and the store pointer into the stage; the store pointer increments.
  - The stage writes memory in the next cycle.
  - The store pointer wraps from MEM_DEPTH-1 to 0.
  - st_base_ld takes priority over an increment in the same cycle; the acked word uses the old pointer.
- all_stored = !stage_vld & !st_req.
- Hazard: a load accept whose mem_addr equals the address of a valid store stage entry (see Optional Feature).
- Simultaneous memory write and read to different addresses are allowed (1R1W memory).

Optional Feature:
- Macro: PE_LD_ST_SERVER_ST_FWD_EN.
- When defined: on a hazard, the load is accepted and the output register takes the store stage data (store-to-load forwarding). Latency stays 1.
- When undefined: on a hazard, ld_desc_rdy = 0 for that cycle. The stage write completes, and the load is accepted the next cycle and reads the new data (1-cycle bubble).

Test Plan:
- Basic store: st_base_ld with st_base = 10, then store 0xA, 0xB with st_req held -> st_ack on consecutive cycles; mem[10] = 0xA, mem[11] = 0xB; all_stored returns to 1 the cycle after the last write.
- Basic stream: ld_stream_len = 2, descriptors (10, reg 3, port 0) and (11, reg 4, port 1), rdy = 1 -> ld_0 = 0xA/addr 3 and ld_1 = 0xB/addr 4 one cycle after each accept; ld_busy falls after DRAIN.
- Backpressure: ld_0_rdy = 0 for 5 cycles -> ld_0_vld and data stay stable; a second port-0 descriptor sees ld_desc_rdy = 0 until the handoff.
- Boundary cases:
  - len = 0 -> stays in IDLE.
  - len pulse during STREAM -> ld_len_err pulses once and remaining is unchanged.
  - Store pointer at MEM_DEPTH-1 -> the next store goes to address 0.
- Hazard: store 0x55 to address 20, then a load of 20 in the next cycle.
  - With PE_LD_ST_SERVER_ST_FWD_EN: accepted immediately, data 0x55.
  - Without: 1-cycle rdy bubble, then data 0x55.
- Reset mid-stream: assert rst with remaining = 3 and ld_0_vld = 1 -> the next cycle shows all vld = 0, ld_busy = 0, all_stored = 1, and an immediate new stream works.
